// File: rtl/alu_multicycle.sv
// WIDTH-bit datapath ALU: single-cycle ADD/SUB/AND/OR/SLT plus iterative
// unsigned MULU (shift-add) and DIVU (restoring) behind a start/busy/done handshake.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div0,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  state_t             state_r;
  state_t             state_s;

  logic [WIDTH-1:0]   dout_r;
  logic [WIDTH-1:0]   dout_hi_r;
  logic               zero_r;
  logic               overflow_r;
  logic               div0_r;
  logic               busy_r;
  logic               done_r;

  // Iteration state: hi_r is partial product / remainder, lo_r is multiplier / quotient.
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   opnd_r;
  logic               div_mode_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               accept_s;
  logic               is_mul_s;
  logic               is_div_s;
  logic               multi_s;
  logic               last_s;

  logic [WIDTH-1:0]   b_neg_s;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH-1:0]   sum_s;
  logic               add_ovf_s;
  logic               slt_s;

  logic [WIDTH-1:0]   sc_lo_s;
  logic [WIDTH-1:0]   sc_hi_s;
  logic               sc_ovf_s;
  logic               sc_div0_s;

  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   step_hi_s;
  logic [WIDTH-1:0]   step_lo_s;

  assign accept_s = start && (state_r != RUN);
  assign is_mul_s = (op == OP_MULU);
  assign is_div_s = (op == OP_DIVU) && (b != {WIDTH{1'b0}});
  assign multi_s  = is_mul_s || is_div_s;
  assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));

  // SUB is formed as a + (~b + 1) so the overflow test sees the negated operand's sign.
  assign b_neg_s   = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
  assign addend_s  = (op == OP_SUB) ? b_neg_s : b;
  assign sum_s     = a + addend_s;
  assign add_ovf_s = (a[WIDTH-1] == addend_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
  assign slt_s     = ($signed(a) < $signed(b));

  // Single-cycle result selection, including the divide-by-zero shortcut
  always_comb begin
    sc_lo_s   = {WIDTH{1'b0}};
    sc_hi_s   = {WIDTH{1'b0}};
    sc_ovf_s  = 1'b0;
    sc_div0_s = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        sc_lo_s  = sum_s;
        sc_ovf_s = add_ovf_s;
      end
      OP_AND:  sc_lo_s = a & b;
      OP_OR:   sc_lo_s = a | b;
      OP_SLT:  sc_lo_s = {{(WIDTH-1){1'b0}}, slt_s};
      OP_DIVU: begin
        sc_lo_s   = {WIDTH{1'b1}};
        sc_hi_s   = a;
        sc_div0_s = 1'b1;
      end
      default: begin
        sc_lo_s = {WIDTH{1'b0}};
        sc_hi_s = {WIDTH{1'b0}};
      end
    endcase
  end

  assign mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
  assign div_shift_s = {hi_r, lo_r[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opnd_r};
  assign div_ge_s    = ~div_diff_s[WIDTH];

  // One multiply or divide iteration per cycle
  always_comb begin
    step_hi_s = hi_r;
    step_lo_s = lo_r;
    if (div_mode_r) begin
      step_hi_s = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
      step_lo_s = {lo_r[WIDTH-2:0], div_ge_s};
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, FIN: begin
        if (accept_s) begin
          state_s = multi_s ? RUN : FIN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = FIN;
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration and registered results
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_r     <= {WIDTH{1'b0}};
      dout_hi_r  <= {WIDTH{1'b0}};
      zero_r     <= 1'b0;
      overflow_r <= 1'b0;
      div0_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      div_mode_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, FIN: begin
          if (accept_s && multi_s) begin
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= is_mul_s ? b : a;
            opnd_r     <= is_mul_s ? a : b;
            div_mode_r <= is_div_s;
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b1;
          end else if (accept_s) begin
            dout_r     <= sc_lo_s;
            dout_hi_r  <= sc_hi_s;
            zero_r     <= (sc_lo_s == {WIDTH{1'b0}});
            overflow_r <= sc_ovf_s;
            div0_r     <= sc_div0_s;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        RUN: begin
          hi_r  <= step_hi_s;
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_s) begin
            dout_r     <= step_lo_s;
            dout_hi_r  <= step_hi_s;
            zero_r     <= (step_lo_s == {WIDTH{1'b0}});
            overflow_r <= 1'b0;
            div0_r     <= 1'b0;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign dout     = dout_r;
  assign dout_hi  = dout_hi_r;
  assign zero     = zero_r;
  assign overflow = overflow_r;
  assign div0     = div0_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: a WIDTH=32 and a WIDTH=8 instance share clk/reset.
module tb_alu_multicycle;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        v;
    logic        d0;
  } res32_t;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       z;
    logic       v;
    logic       d0;
  } res8_t;

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND = 4'b0000, OR = 4'b0001;
  localparam logic [3:0] SLT = 4'b0111, MULU = 4'b1000, DIVU = 4'b1001;

  logic        clk, reset;
  logic        start32, start8;
  logic [3:0]  op32, op8;
  logic [31:0] a32, b32, dout32, hi32;
  logic [7:0]  a8, b8, dout8, hi8;
  logic        zero32, ovf32, div032, busy32, done32;
  logic        zero8, ovf8, div08, busy8, done8;

  int total = 0;
  int bad = 0;
  res32_t q32[$];
  int     lq32[$];
  res8_t  q8[$];
  int     lq8[$];

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .dout(dout32), .dout_hi(hi32), .zero(zero32), .overflow(ovf32), .div0(div032),
    .busy(busy32), .done(done32)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .dout(dout8), .dout_hi(hi8), .zero(zero8), .overflow(ovf8), .div0(div08),
    .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output res32_t r, output int lat);
    logic [63:0] p;
    logic [31:0] bp;
    r = '0;
    lat = 1;
    case (o)
      ADD: begin
        r.lo = x + y;
        r.v  = (x[31] == y[31]) && (r.lo[31] != x[31]);
      end
      SUB: begin
        bp   = ~y + 32'd1;
        r.lo = x - y;
        r.v  = (x[31] == bp[31]) && (r.lo[31] != x[31]);
      end
      AND: r.lo = x & y;
      OR:  r.lo = x | y;
      SLT: r.lo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      MULU: begin
        p    = {32'd0, x} * {32'd0, y};
        r.lo = p[31:0];
        r.hi = p[63:32];
        lat  = 33;
      end
      DIVU: begin
        if (y == 32'd0) begin
          r.lo = 32'hFFFF_FFFF;
          r.hi = x;
          r.d0 = 1'b1;
        end else begin
          r.lo = x / y;
          r.hi = x % y;
          lat  = 33;
        end
      end
      default: r = '0;
    endcase
    r.z = (r.lo == 32'd0);
  endfunction

  function automatic res32_t obs32();
    return {dout32, hi32, zero32, ovf32, div032};
  endfunction

  function automatic res8_t obs8();
    return {dout8, hi8, zero8, ovf8, div08};
  endfunction

  task automatic issue32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    res32_t r;
    int l;
    model32(o, x, y, r, l);
    q32.push_back(r);
    lq32.push_back(l);
    start32 = 1'b1; op32 = o; a32 = x; b32 = y;
    @(negedge clk);
    start32 = 1'b0; op32 = 4'($urandom); a32 = $urandom; b32 = $urandom;
  endtask

  task automatic wait_done32(output int n);
    n = 1;
    while (done32 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issue8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input res8_t r, input int l);
    q8.push_back(r);
    lq8.push_back(l);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; op8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic wait_done8(output int n);
    n = 1;
    while (done8 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    total++;
    if (obs32() !== '0 || busy32 !== 1'b0 || done32 !== 1'b0) begin
      bad++;
      $display("FAIL reset32: got out=%h busy=%b done=%b want all zero", obs32(), busy32, done32);
    end
    total++;
    if (obs8() !== '0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      bad++;
      $display("FAIL reset8: got out=%h busy=%b done=%b want all zero", obs8(), busy8, done8);
    end
  endtask

  task automatic test_add_sub();
    logic [3:0]  ops [5];
    logic [31:0] as [5];
    logic [31:0] bs [5];
    res32_t e;
    int n, l;
    ops = '{ADD, SUB, ADD, SUB, SUB};
    as  = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3};
    bs  = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd10};
    for (int i = 0; i < 5; i++) begin
      issue32(ops[i], as[i], bs[i]);
      wait_done32(n);
      e = q32.pop_front();
      l = lq32.pop_front();
      total++;
      if (n !== l) begin bad++; $display("FAIL add_sub_lat[%0d]: got %0d want %0d", i, n, l); end
      total++;
      if (obs32() !== e) begin bad++; $display("FAIL add_sub[%0d]: got %h want %h", i, obs32(), e); end
    end
    @(negedge clk);
    total++;
    if (done32 !== 1'b0 || obs32() !== e) begin
      bad++;
      $display("FAIL done_pulse_hold: got done=%b out=%h want done=0 out=%h", done32, obs32(), e);
    end
  endtask

  task automatic test_logic_slt();
    logic [3:0]  ops [7];
    logic [31:0] as [7];
    logic [31:0] bs [7];
    res32_t e;
    int n, l;
    ops = '{SLT, SLT, SLT, AND, OR, 4'b0011, 4'b1010};
    as  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_F0F0, 32'h0000_F0F0, 32'hFFFF_FFFF, 32'h1234_5678};
    bs  = '{32'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_FF00, 32'h0000_FF00, 32'hFFFF_FFFF, 32'h9};
    for (int i = 0; i < 7; i++) begin
      issue32(ops[i], as[i], bs[i]);
      wait_done32(n);
      e = q32.pop_front();
      l = lq32.pop_front();
      total++;
      if (n !== l) begin bad++; $display("FAIL logic_lat[%0d]: got %0d want %0d", i, n, l); end
      total++;
      if (obs32() !== e) begin bad++; $display("FAIL logic[%0d]: got %h want %h", i, obs32(), e); end
    end
    @(negedge clk);
  endtask

  task automatic test_mulu();
    res32_t e;
    int n, l;
    issue32(MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 32; k++) begin
      total++;
      if (busy32 !== 1'b1 || done32 !== 1'b0) begin
        bad++;
        $display("FAIL mulu_busy[T+%0d]: got busy=%b done=%b want busy=1 done=0", k, busy32, done32);
      end
      if (k == 5) begin
        start32 = 1'b1; op32 = ADD; a32 = 32'd1; b32 = 32'd1;
      end else begin
        start32 = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (done32 !== 1'b1 || busy32 !== 1'b0) begin
      bad++;
      $display("FAIL mulu_done_T33: got done=%b busy=%b want done=1 busy=0", done32, busy32);
    end
    e = q32.pop_front();
    l = lq32.pop_front();
    total++;
    if (obs32() !== e) begin bad++; $display("FAIL mulu_max: got %h want %h", obs32(), e); end
    @(negedge clk);
    total++;
    if (done32 !== 1'b0) begin bad++; $display("FAIL mulu_pulse: got done=%b want 0", done32); end
    for (int i = 0; i < 3; i++) begin
      issue32(MULU, $urandom, $urandom);
      wait_done32(n);
      e = q32.pop_front();
      l = lq32.pop_front();
      total++;
      if (n !== l) begin bad++; $display("FAIL mulu_lat[%0d]: got %0d want %0d", i, n, l); end
      total++;
      if (obs32() !== e) begin bad++; $display("FAIL mulu_rand[%0d]: got %h want %h", i, obs32(), e); end
    end
    @(negedge clk);
  endtask

  task automatic test_divu();
    logic [31:0] as [5];
    logic [31:0] bs [5];
    res32_t e;
    int n, l;
    as = '{32'd100, 32'd5, 32'hFFFF_FFFF, $urandom, 32'd9};
    bs = '{32'd7, 32'd100, 32'd1, 32'(($urandom % 1000) + 1), 32'd0};
    for (int i = 0; i < 5; i++) begin
      issue32(DIVU, as[i], bs[i]);
      wait_done32(n);
      e = q32.pop_front();
      l = lq32.pop_front();
      total++;
      if (n !== l) begin bad++; $display("FAIL divu_lat[%0d]: got %0d want %0d", i, n, l); end
      total++;
      if (obs32() !== e) begin bad++; $display("FAIL divu[%0d]: got %h want %h", i, obs32(), e); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    res32_t e;
    int n, l;
    logic saw_done;
    issue32(MULU, 32'h1234_5678, 32'h0000_0009);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(q32.pop_front());
    void'(lq32.pop_front());
    total++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || obs32() !== '0) begin
      bad++;
      $display("FAIL abort_clear: got busy=%b done=%b out=%h want all zero", busy32, done32, obs32());
    end
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done32 === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    total++;
    if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done: got done seen=%b want 0", saw_done); end
    issue32(ADD, 32'd2, 32'd3);
    wait_done32(n);
    e = q32.pop_front();
    l = lq32.pop_front();
    total++;
    if (n !== l || obs32() !== e) begin
      bad++;
      $display("FAIL abort_then_add: got lat=%0d out=%h want lat=%0d out=%h", n, obs32(), l, e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4];
    logic [31:0] as [4];
    logic [31:0] bs [4];
    res32_t e;
    int n, l;
    ops = '{ADD, SUB, MULU, ADD};
    as  = '{32'd10, 32'd5, 32'h0001_0000, 32'h8000_0000};
    bs  = '{32'd20, 32'd5, 32'h0003_0000, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      issue32(ops[i], as[i], bs[i]);
      wait_done32(n);
      e = q32.pop_front();
      l = lq32.pop_front();
      total++;
      if (n !== l) begin bad++; $display("FAIL b2b_lat[%0d]: got %0d want %0d", i, n, l); end
      total++;
      if (obs32() !== e) begin bad++; $display("FAIL b2b[%0d]: got %h want %h", i, obs32(), e); end
    end
    @(negedge clk);
  endtask

  task automatic test_width8();
    logic [3:0] ops [5];
    logic [7:0] as [5];
    logic [7:0] bs [5];
    res8_t      rs [5];
    int         ls [5];
    res8_t e;
    int n, l;
    ops = '{MULU, ADD, ADD, DIVU, SUB};
    as  = '{8'hFF, 8'h10, 8'h7F, 8'd200, 8'h03};
    bs  = '{8'h02, 8'h20, 8'h01, 8'd13, 8'h03};
    rs  = '{{8'hFE, 8'h01, 1'b0, 1'b0, 1'b0}, {8'h30, 8'h00, 1'b0, 1'b0, 1'b0},
            {8'h80, 8'h00, 1'b0, 1'b1, 1'b0}, {8'h0F, 8'h05, 1'b0, 1'b0, 1'b0},
            {8'h00, 8'h00, 1'b1, 1'b0, 1'b0}};
    ls  = '{9, 1, 1, 9, 1};
    for (int i = 0; i < 5; i++) begin
      issue8(ops[i], as[i], bs[i], rs[i], ls[i]);
      wait_done8(n);
      e = q8.pop_front();
      l = lq8.pop_front();
      total++;
      if (n !== l) begin bad++; $display("FAIL w8_lat[%0d]: got %0d want %0d", i, n, l); end
      total++;
      if (obs8() !== e) begin bad++; $display("FAIL w8[%0d]: got %h want %h", i, obs8(), e); end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start32 = 1'b0; op32 = 4'd0; a32 = 32'd0; b32 = 32'd0;
    start8 = 1'b0;  op8 = 4'd0;  a8 = 8'd0;   b8 = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_add_sub();
    test_logic_slt();
    test_mulu();
    test_divu();
    test_reset_abort();
    test_back_to_back();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Parametrised WIDTH-bit ALU for the datapath, extending the 32-bit ADD/SUB/AND/OR/SLT ALU.
- Keeps the same 3-bit operation encodings.
- Adds iterative unsigned multiply and divide, plus status flags.
- Uses a start/busy/done handshake, so the control FSM stalls on multi-cycle ops.
- Sits between the register-file read stage and writeback.

Parameters:
WIDTH, 32, operand/result width; legal range 4..64.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
clk        input   1      rising-edge clock
reset      input   1      synchronous, active-high; clears all state and outputs
start      input   1      op request; accepted only when busy==0
op         input   4      op[3]=0: op[2:0] uses classic codes 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT; op[3]=1: 1000 MULU, 1001 DIVU
a          input   WIDTH  operand A; sampled at accept
b          input   WIDTH  operand B; sampled at accept
dout       output  WIDTH  result; quotient for DIVU, low product for MULU
dout_hi    output  WIDTH  high product (MULU), remainder (DIVU), 0 otherwise
zero       output  1      dout == 0
overflow   output  1      signed overflow for ADD/SUB, 0 otherwise
div0       output  1      DIVU issued with b==0
busy       output  1      op in progress
done       output  1      one-cycle pulse; results valid from this cycle

Behaviour:
- States: IDLE, RUN, FIN.
- Reset: state IDLE; dout, dout_hi, zero, overflow, div0, busy, done = 0; counter = 0. Reset during RUN aborts the op and reports no done.
- Accept: start=1 in IDLE, or in FIN. a, b and op are latched. Inputs change freely after accept.
- start while in RUN: ignored, no queuing.
- Single-cycle ops (ADD, SUB, AND, OR, SLT, undefined codes): accept at cycle T, then at T+1 the outputs are registered, done=1, busy=0.
- ADD/SUB wrap modulo 2^WIDTH.
- overflow = (sign(a)==sign(b')) && (sign(result)!=sign(a)), where b' = b for ADD and ~b+1 for SUB.
- SLT is signed and must be correct on overflow: dout = 1 iff $signed(a) < $signed(b). Example: a=0x7FFFFFFF, b=0x80000000 -> 0.
- Undefined codes: dout=0, dout_hi=0.
- MULU: shift-add, one bit per cycle.
  - Accept at T; busy=1 from T+1 through T+WIDTH.
  - done and results at T+WIDTH+1.
  - {dout_hi,dout} = a*b, full 2*WIDTH product.
- DIVU: restoring division, one bit per cycle, same timing as MULU.
  - dout = a/b, dout_hi = a%b.
- DIVU with b==0: takes the single-cycle path (done at T+1). dout = all ones, dout_hi = a, div0=1.
- div0 is 0 for every other op.
- zero is computed from the final dout.
- FIN lasts one cycle, then IDLE.
- Outputs hold their last value until the next op's done. Only done returns to 0.
- A start accepted in FIN is treated as a new op: no bubble between back-to-back ops.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF, b=1 -> at T+1: dout=0x80000000, overflow=1, zero=0, done pulse 1 cycle. SUB a=5, b=5 -> dout=0, zero=1, overflow=0.
- SLT a=0xFFFFFFFF (-1), b=1 -> dout=1. a=0x7FFFFFFF, b=0x80000000 -> dout=0. AND 0xF0F0 & 0xFF00 -> 0xF000. OR -> 0xFFF0.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly at T+33: dout=0x00000001, dout_hi=0xFFFFFFFE. start pulsed at T+5 is ignored; busy=1 T+1..T+32.
- DIVU a=100, b=7 -> T+33: dout=14, dout_hi=2. DIVU a=9, b=0 -> T+1: dout=0xFFFFFFFF, dout_hi=9, div0=1.
- Reset asserted at T+10 of a MULU -> next cycle busy=0, all outputs 0, no done. A new ADD 2+3 accepted afterwards -> dout=5.
- WIDTH=8: MULU 0xFF*0x02 -> dout=0xFE, dout_hi=0x01, done at T+9. Back-to-back ADD issued in the done cycle -> done again next cycle.
